range_input_conditioner: RTL

//  Front-end stage feeding the range-finder core. Takes raw asynchronous pins from io_in
//  (data bus, GO button, FINISH button) and produces what the core consumes:
//  - synchronized, debounced data_in;
//  - single-cycle go/finish pulses;
//  - a sticky collision flag.
//  The core samples data_in on every edge where go or finish is high.

---
 rtl/range_pkg.sv | 15 +
 rtl/range_input_conditioner_if.sv | 27 ++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/range_input_conditioner.sv | 84 ++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared definitions for the range-finder front end and core.
// Bus width and debounce-counter sizing live here so both sides agree.
package range_pkg;

    localparam int DATA_W           = 8;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef logic [DATA_W-1:0] data_t;

    // One spare bit above the terminal count keeps the compare free of wrap concerns.
    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/range_input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw pins in, conditioned signals out.
// The board or bench drives through master; the conditioner attaches as slave.
interface range_input_conditioner_if
    import range_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic [WIDTH-1:0] data_raw;
    logic             go_raw;
    logic             finish_raw;
    logic [WIDTH-1:0] data_in;
    logic             go;
    logic             finish;
    logic             collision;

    modport master (
        output data_raw, go_raw, finish_raw,
        input  data_in, go, finish, collision
    );

    modport slave (
        input  data_raw, go_raw, finish_raw,
        output data_in, go, finish, collision
    );

endinterface

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter, debounced level,
// arming after a genuine release, and a registered single-cycle rising-edge pulse.
module btn_debounce
    import range_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int                CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_level;
    logic [1:0]       sync_fill;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_prev;
    logic             armed;
    logic             differ;
    logic             flip;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        differ = sync_level ^ level;
        flip   = differ && (cnt == CNT_LAST);
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            sync_fill  <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            armed      <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
            sync_fill  <= {sync_fill[0], 1'b1};

            // The reset zeros in the synchronizer are not a real release; wait until
            // a post-reset pin sample has reached sync_level before arming.
            if (sync_fill[1] && !sync_level) begin
                armed <= 1'b1;
            end

            if (!differ || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (flip) begin
                level <= sync_level;
            end

            level_prev <= level;
            pulse      <= level && !level_prev && armed;
        end
    end

endmodule

// File: rtl/range_input_conditioner.sv
// Front end of the range finder: conditions raw GO/FINISH buttons and the data bus,
// arbitrates simultaneous GO/FINISH, and keeps a sticky collision flag.
module range_input_conditioner
    import range_pkg::*;
#(
    parameter int WIDTH           = DATA_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input logic                      clock,
    input logic                      reset,
    range_input_conditioner_if.slave io
);

    localparam int               CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             go_pulse;
    logic             finish_pulse;
    logic             collision_q;
    logic [WIDTH-1:0] data_meta;
    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] data_prev;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] data_cnt;
    logic             data_stable;
    logic             data_load;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_btn (
        .clock (clock),
        .reset (reset),
        .raw   (io.go_raw),
        .pulse (go_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_finish_btn (
        .clock (clock),
        .reset (reset),
        .raw   (io.finish_raw),
        .pulse (finish_pulse)
    );

    // The extra data_prev stage aligns the load with the button pulse edge, so the
    // core samples freshly settled data together with go/finish.
    always_comb begin
        data_stable = (data_sync == data_prev);
        data_load   = data_stable && (data_cnt == CNT_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_meta   <= '0;
            data_sync   <= '0;
            data_prev   <= '0;
            data_cnt    <= '0;
            data_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            data_meta <= io.data_raw;
            data_sync <= data_meta;
            data_prev <= data_sync;

            if (!data_stable || data_load) begin
                data_cnt <= '0;
            end else begin
                data_cnt <= data_cnt + CNT_W'(1);
            end

            if (data_load) begin
                data_q <= data_sync;
            end

            if (go_pulse && finish_pulse) begin
                collision_q <= 1'b1;
            end
        end
    end

    // FINISH wins a same-edge tie; collision is visible on that very edge.
    assign io.data_in   = data_q;
    assign io.go        = go_pulse && !finish_pulse;
    assign io.finish    = finish_pulse;
    assign io.collision = collision_q || (go_pulse && finish_pulse);

endmodule
